// File: rtl/uart_receiver.sv
// UART receive engine: synchronises rx, samples mid-bit on bclk ticks, deframes
// start/data/stop and presents bytes via a valid/ack holding register. Optional parity: UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bclk,
  input  logic              rx,
  input  logic              rx_ack,
`ifdef UART_RX_PARITY_EN
  input  logic              parity_odd,
`endif
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              overrun_err,
  output logic              parity_err,
  output logic              busy,
  output logic [2:0]        fsm_state
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state;
  logic              rx_meta;
  logic              rx_s;
  logic              bclk_q;
  logic              tick;
  logic [CNT_W-1:0]  tick_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
`ifdef UART_RX_PARITY_EN
  logic              par_bad;
`endif

  assign tick      = bclk & ~bclk_q;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Valid/ready contract: rx_valid stays high until a cycle with rx_ack; a frame
  // completing in that same cycle reloads rx_data and keeps rx_valid high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      bclk_q      <= 1'b0;
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
      par_bad     <= 1'b0;
`endif
    end else begin
      rx_meta     <= rx;
      rx_s        <= rx_meta;
      bclk_q      <= bclk;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_ack && rx_valid)
        rx_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (tick) begin
            if (tick_cnt == HALF_END) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (tick_cnt == FULL_END) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[DATA_W-1:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (tick_cnt == FULL_END) begin
              tick_cnt <= '0;
              par_bad  <= ((^shreg) ^ rx_s) != parity_odd;
              state    <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        ST_STOP: begin
          if (tick) begin
            if (tick_cnt == FULL_END) begin
              tick_cnt  <= '0;
              state     <= ST_IDLE;
              frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              if (!rx_valid || rx_ack) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
